// File: rtl/multi_channel_counter_if.sv
// Command/result bundle for multi_channel_counter.
// The master drives the channel commands; the slave returns the counts and wrap pulses.
interface multi_channel_counter_if #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned DIV_W    = 3
);
  logic                      En;
  logic [SEL_W-1:0]          Slt;
  logic                      Clr;
  logic                      Div_we;
  logic [DIV_W-1:0]          Div_val;
  logic [CHANNELS*WIDTH-1:0] Count;
  logic [CHANNELS-1:0]       Wrap;

  modport master (output En, Slt, Clr, Div_we, Div_val, input  Count, Wrap);
  modport slave  (input  En, Slt, Clr, Div_we, Div_val, output Count, Wrap);
endinterface

// File: rtl/multi_channel_counter.sv
// N-channel event counter with a per-channel programmable prescaler.
// Optional macro SATURATE_EN: counts hold at all-ones instead of wrapping to zero.
module multi_channel_counter #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned DIV_W    = 3
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  multi_channel_counter_if.slave bus
);

  localparam int unsigned CMP_W = SEL_W + 1;

  logic                      w_valid;
  logic [CHANNELS*WIDTH-1:0] w_count_flat;
  logic [CHANNELS-1:0]       w_wrap_vec;

  // Selects beyond the last channel are ignored entirely
  assign w_valid = ({1'b0, bus.Slt} < CMP_W'(CHANNELS));

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [DIV_W-1:0] r_pre;
    logic [DIV_W-1:0] w_pre_nxt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_nxt;
    logic             r_wrap;
    logic             w_wrap_nxt;
    logic             w_hit;
    logic             w_inc;
    logic             w_full;

    assign w_hit = w_valid && (bus.Slt == SEL_W'(k));

    // Clr/Div_we pre-empt the event; both may apply together
    always_comb begin
      w_count_nxt = r_count;
      w_pre_nxt   = r_pre;
      w_div_nxt   = r_div;
      w_wrap_nxt  = 1'b0;
      w_inc       = 1'b0;
      w_full      = &r_count;
      if (w_hit) begin
        if (bus.Clr || bus.Div_we) begin
          w_pre_nxt = '0;
          if (bus.Clr)    w_count_nxt = '0;
          if (bus.Div_we) w_div_nxt   = bus.Div_val;
        end else if (bus.En) begin
          if (r_pre == r_div) begin
            w_pre_nxt = '0;
            w_inc     = 1'b1;
          end else begin
            w_pre_nxt = r_pre + DIV_W'(1);
          end
        end
      end
      if (w_inc) begin
        w_wrap_nxt = w_full;
`ifdef SATURATE_EN
        if (!w_full) w_count_nxt = r_count + WIDTH'(1);
`else
        w_count_nxt = r_count + WIDTH'(1);
`endif
      end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        r_count <= '0;
        r_pre   <= '0;
        r_div   <= '0;
        r_wrap  <= 1'b0;
      end else begin
        r_count <= w_count_nxt;
        r_pre   <= w_pre_nxt;
        r_div   <= w_div_nxt;
        r_wrap  <= w_wrap_nxt;
      end
    end

    assign w_count_flat[k*WIDTH +: WIDTH] = r_count;
    assign w_wrap_vec[k]                  = r_wrap;
  end

  assign bus.Count = w_count_flat;
  assign bus.Wrap  = w_wrap_vec;

endmodule
